// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared state encoding, default widths and beat layout for the MEM->WB stage.
package mem_wb_pkg;

    localparam int MEM_WB_DATA_W = 32;
    localparam int MEM_WB_REG_AW = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [MEM_WB_DATA_W-1:0] alu;
        logic [MEM_WB_DATA_W-1:0] dm;
        logic [MEM_WB_DATA_W-1:0] pc4;
        logic [MEM_WB_REG_AW-1:0] rtd;
        logic                     rfwe;
        logic                     mtorf;
        logic                     jump;
    } beat_t;

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready buffer with flush; two entries (registered ready) when
// MEM_WB_SKID_EN is defined, otherwise a single register with combinational ready.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    state_t state, state_d;
    logic [W-1:0] main_q, main_d;
    logic acc, drn;

    assign out_valid = state != EMPTY;
    assign drn       = out_valid && out_ready;
    assign acc       = in_valid && in_ready && !flush;
    // Head data reads as zero whenever nothing is held
    assign out_data  = out_valid ? main_q : '0;
    assign occ       = state == TWO ? 2'd2 : {1'b0, out_valid};

`ifdef MEM_WB_SKID_EN
    logic [W-1:0] skid_q, skid_d;

    assign in_ready = state != TWO;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush)
            state_d = EMPTY;
        else
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && drn)
                        main_d = in_data;
                    else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (drn)
                        state_d = EMPTY;
                end
                default: begin
                    if (drn) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
            endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        if (flush)
            state_d = EMPTY;
        else if (acc) begin
            state_d = ONE;
            main_d  = in_data;
        end else if (drn)
            state_d = EMPTY;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= EMPTY;
            main_q <= '0;
        end else begin
            state  <= state_d;
            main_q <= main_d;
        end
    end
`endif

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: elastic MEM->WB register with writeback result select and qualified RF write.
// Define MEM_WB_SKID_EN for the two-entry skid variant.
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = MEM_WB_DATA_W,
    parameter int REG_AW = MEM_WB_REG_AW
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FlushM,
    input  logic              ValidM,
    output logic              ReadyM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] DMOutM,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [REG_AW-1:0] rtdM,
    input  logic              RFWEM,
    input  logic              MtoRFSelM,
    input  logic              JumpM,
    output logic              ValidW,
    input  logic              ReadyW,
    output logic [DATA_W-1:0] ResultW,
    output logic [REG_AW-1:0] rtdW,
    output logic              RFWEW,
    output logic [1:0]        OccW
);

    // Same layout as mem_wb_pkg::beat_t, sized by this instance's parameters
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] dm;
        logic [DATA_W-1:0] pc4;
        logic [REG_AW-1:0] rtd;
        logic              rfwe;
        logic              mtorf;
        logic              jump;
    } pbeat_t;

    pbeat_t in_beat, head;

    assign in_beat = '{alu: ALUOutM, dm: DMOutM, pc4: PCPlus4M, rtd: rtdM,
                       rfwe: RFWEM, mtorf: MtoRFSelM, jump: JumpM};

    pipe_skid_buf #(.W($bits(pbeat_t))) u_buf (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .flush    (FlushM),
        .in_valid (ValidM),
        .in_ready (ReadyM),
        .in_data  (in_beat),
        .out_valid(ValidW),
        .out_ready(ReadyW),
        .out_data (head),
        .occ      (OccW)
    );

    assign ResultW = head.jump ? head.pc4 : (head.mtorf ? head.dm : head.alu);
    assign rtdW    = head.rtd;
    assign RFWEW   = ValidW && ReadyW && head.rfwe && (head.rtd != '0);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed table plus hand sequences for stall, flush and async reset.
module tb_mem_wb_pipe;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FlushM = 1'b0, ValidM = 1'b0, ReadyW = 1'b0;
    logic        RFWEM = 1'b0, MtoRFSelM = 1'b0, JumpM = 1'b0;
    logic [31:0] ALUOutM = '0, DMOutM = '0, PCPlus4M = '0;
    logic [4:0]  rtdM = '0;
    logic        ReadyM, ValidW, RFWEW;
    logic [31:0] ResultW;
    logic [4:0]  rtdW;
    logic [1:0]  OccW;

    int tests = 0, fails = 0;

    mem_wb_pipe dut (
        .CLK(CLK), .RST_N(RST_N), .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
        .ALUOutM(ALUOutM), .DMOutM(DMOutM), .PCPlus4M(PCPlus4M), .rtdM(rtdM),
        .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .JumpM(JumpM), .ValidW(ValidW),
        .ReadyW(ReadyW), .ResultW(ResultW), .rtdW(rtdW), .RFWEW(RFWEW), .OccW(OccW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        vm, rw, mtorf, jump, rfwe;
        logic [31:0] alu, dm, pc4;
        logic [4:0]  rtd;
        logic        ev, erm, erf;
        logic [31:0] eres;
        logic [4:0]  ertd;
        logic [1:0]  eocc;
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(logic vm, logic [31:0] alu, logic [31:0] dm, logic [31:0] pc4,
                                logic [4:0] rtd, logic rfwe, logic mtorf, logic jump,
                                logic ev, logic [31:0] eres, logic [4:0] ertd, logic erf,
                                logic [1:0] eocc);
        vec_t v;
        v.vm = vm; v.rw = 1'b1; v.alu = alu; v.dm = dm; v.pc4 = pc4; v.rtd = rtd;
        v.rfwe = rfwe; v.mtorf = mtorf; v.jump = jump;
        v.ev = ev; v.erm = 1'b1; v.eres = eres; v.ertd = ertd; v.erf = erf; v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic ev, logic erm, logic [31:0] eres,
                           logic [4:0] ertd, logic erf, logic [1:0] eocc);
        chk({tag, ".ValidW"}, 32'(ValidW), 32'(ev));
        chk({tag, ".ReadyM"}, 32'(ReadyM), 32'(erm));
        chk({tag, ".ResultW"}, ResultW, eres);
        chk({tag, ".rtdW"}, 32'(rtdW), 32'(ertd));
        chk({tag, ".RFWEW"}, 32'(RFWEW), 32'(erf));
        chk({tag, ".OccW"}, 32'(OccW), 32'(eocc));
    endtask

    task automatic beat(logic vm, logic [31:0] alu, logic rw, logic fl);
        @(posedge CLK); #1;
        ValidM = vm; ALUOutM = alu; ReadyW = rw; FlushM = fl;
        rtdM = 5'd2; RFWEM = 1'b1; MtoRFSelM = 1'b0; JumpM = 1'b0;
        DMOutM = 32'hBAD; PCPlus4M = 32'h200;
        #3;
    endtask

    initial begin
        vt[0] = mk(1, 32'h11, 32'hBAD, 32'h200, 5,  1, 0, 0, 0, 32'h0,        0,  0, 0);
        vt[1] = mk(1, 32'h22, 32'hBAD, 32'h200, 5,  1, 0, 0, 1, 32'h11,       5,  1, 1);
        vt[2] = mk(1, 32'h33, 32'hBAD, 32'h200, 5,  1, 0, 0, 1, 32'h22,       5,  1, 1);
        vt[3] = mk(1, 32'h4,  32'hDEADBEEF, 32'h200, 7, 1, 1, 0, 1, 32'h33,   5,  1, 1);
        vt[4] = mk(1, 32'h55, 32'hBAD, 32'h104, 31, 1, 0, 1, 1, 32'hDEADBEEF, 7,  1, 1);
        vt[5] = mk(1, 32'h66, 32'hBAD, 32'h200, 0,  1, 0, 0, 1, 32'h104,      31, 1, 1);
        vt[6] = mk(1, 32'h77, 32'hBAD, 32'h200, 3,  0, 0, 0, 1, 32'h66,       0,  0, 1);
        vt[7] = mk(0, 32'h0,  32'h0,   32'h0,   0,  0, 0, 0, 1, 32'h77,       3,  0, 1);
        vt[8] = mk(0, 32'h0,  32'h0,   32'h0,   0,  0, 0, 0, 0, 32'h0,        0,  0, 0);

        #2;
        chk_all("reset", 0, 1, 32'h0, 0, 0, 0);
        @(negedge CLK) RST_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(posedge CLK); #1;
            ValidM = vt[i].vm; ReadyW = vt[i].rw; FlushM = 1'b0;
            ALUOutM = vt[i].alu; DMOutM = vt[i].dm; PCPlus4M = vt[i].pc4; rtdM = vt[i].rtd;
            RFWEM = vt[i].rfwe; MtoRFSelM = vt[i].mtorf; JumpM = vt[i].jump;
            #3;
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].erm, vt[i].eres, vt[i].ertd,
                    vt[i].erf, vt[i].eocc);
        end

        // Stall with ReadyW low, then release; beats must come out A then B
        beat(1, 32'hA, 0, 0);
        chk_all("st_a", 0, 1, 32'h0, 0, 0, 0);
`ifdef MEM_WB_SKID_EN
        beat(1, 32'hB, 0, 0);
        chk_all("st_b", 1, 1, 32'hA, 2, 0, 1);
        beat(0, 32'h0, 0, 0);
        chk_all("st_full", 1, 0, 32'hA, 2, 0, 2);
        beat(0, 32'h0, 1, 0);
        chk_all("st_rel_a", 1, 0, 32'hA, 2, 1, 2);
        beat(0, 32'h0, 1, 0);
        chk_all("st_rel_b", 1, 1, 32'hB, 2, 1, 1);
`else
        beat(1, 32'hB, 0, 0);
        chk_all("st_b", 1, 0, 32'hA, 2, 0, 1);
        ReadyW = 1'b1;
        #1;
        chk_all("st_rel_a", 1, 1, 32'hA, 2, 1, 1);
        beat(0, 32'h0, 1, 0);
        chk_all("st_rel_b", 1, 1, 32'hB, 2, 1, 1);
`endif
        beat(0, 32'h0, 1, 0);
        chk_all("st_done", 0, 1, 32'h0, 0, 0, 0);

        // Flush with a drain and a new beat in the same cycle
        beat(1, 32'hA, 0, 0);
`ifdef MEM_WB_SKID_EN
        beat(1, 32'hB, 0, 0);
        beat(1, 32'hC, 1, 1);
        chk_all("fl_edge", 1, 0, 32'hA, 2, 1, 2);
`else
        beat(1, 32'hC, 1, 1);
        chk_all("fl_edge", 1, 1, 32'hA, 2, 1, 1);
`endif
        for (int i = 0; i < 3; i++) begin
            beat(0, 32'h0, 1, 0);
            chk_all($sformatf("fl_after%0d", i), 0, 1, 32'h0, 0, 0, 0);
        end

        // Asynchronous reset between clock edges with a beat at the head
        beat(1, 32'h5A, 1, 0);
        beat(1, 32'h6B, 1, 0);
        chk_all("ar_pre", 1, 1, 32'h5A, 2, 1, 1);
        #1 RST_N = 1'b0;
        #1;
        chk_all("ar_now", 0, 1, 32'h0, 0, 0, 0);
        @(posedge CLK); #2;
        chk_all("ar_hold", 0, 1, 32'h0, 0, 0, 0);
        ValidM = 1'b0;
        @(negedge CLK) RST_N = 1'b1;
        beat(0, 32'h0, 1, 0);
        chk_all("ar_after", 0, 1, 32'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised, elastic MEM→WB pipeline register for the pipelined core. Unlike the fixed-width always-advance stage register, it carries a valid/ready handshake on both sides. It buffers up to two beats so that a WB-side stall does not combinationally stall MEM. It supports a synchronous flush and performs the writeback result selection (ALU / data memory / link address), presenting a qualified register-file write port to the register file.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- FlushM  in  1  synchronous flush; discards all buffered beats and the incoming beat
- ValidM  in  1  MEM presents a beat
- ReadyM  out  1  stage can accept a beat
- ALUOutM  in  DATA_W  ALU result
- DMOutM  in  DATA_W  data-memory read data
- PCPlus4M  in  DATA_W  link address for jump-and-link
- rtdM  in  REG_AW  destination register
- RFWEM, MtoRFSelM, JumpM  in  1 each  control bits
- ValidW  out  1  head beat valid
- ReadyW  in  1  WB consumes head beat
- ResultW  out  DATA_W  selected writeback value of head beat
- rtdW  out  REG_AW  head destination
- RFWEW  out  1  register-file write strobe
- OccW  out  2  beats held (0..2)

## Operation
- Accept: ValidM && ReadyM at a rising edge. Drain: ValidW && ReadyW at a rising edge.
- Result select for the head beat: JumpW ? PCPlus4 : (MtoRFSelW ? DMOut : ALUOut).
- RFWEW = ValidW && ReadyW && RFWE && (rtdW != 0).
  - The write commits at the drain edge.
  - Writes to register 0 are always suppressed.
- State machine (held in main and skid registers):
  - EMPTY: accept → ONE.
  - ONE:
    - accept only → TWO (beat into skid).
    - drain only → EMPTY.
    - accept and drain → ONE (main replaced).
  - TWO:
    - Drain → ONE; skid moves to main.
    - No accept is possible in TWO because ReadyM=0.
- Ordering is strictly FIFO; no beat is duplicated or reordered.
- Flush has the highest priority:
  - The next state is EMPTY and the incoming beat is dropped.
  - A drain in the same cycle still commits (RFWEW is high for that edge).
- Reset values:
  - State: EMPTY; OccW = 0; ValidW = 0; ReadyM = 1.
  - ResultW = 0, rtdW = 0, RFWEW = 0.
  - All stored fields are 0.
- Reset asserted mid-operation: all held beats are lost immediately (asynchronous), and the outputs take their reset values in the same instant.

## Timing
- Latency: 1 cycle from accept to ValidW.
- Throughput: 1 beat/cycle when ReadyW stays high.
- ReadyM is a registered output: 1 in EMPTY or ONE, 0 in TWO.
  - There is no combinational path from ReadyW to ReadyM.
- ResultW and RFWEW are combinational from the head register plus ReadyW; there is no path from any M-side input.
- ReadyW low with one beat held: the next accept fills skid, and ReadyM falls the following cycle.

## Configuration
- MEM_WB_SKID_EN defined:
  - Two-entry skid buffer as described above.
  - ReadyM is registered.
  - OccW ranges 0..2.
- MEM_WB_SKID_EN undefined:
  - Single register; states EMPTY/ONE only.
  - ReadyM = !ValidW || ReadyW, which is combinational.
  - OccW ranges 0..1.
  - Latency, flush, reset and RFWEW rules are unchanged.

## Structure
- Package mem_wb_pkg holds:
  - State enum (EMPTY, ONE, TWO).
  - Default widths.
  - Beat struct: alu, dm, pc4, rtd, rfwe, mtorf, jump.
- Sub-module pipe_skid_buf: generic width-parametrised valid/ready skid buffer carrying the packed beat struct.
  - It contains the state machine, the flush logic and the macro switch.
  - The top level instantiates it and adds the result mux and the RFWEW qualification.

## Test plan
- Reset, then stream ALUOutM=0x11,0x22,0x33 with RFWE=1, rtd=5, ReadyW=1 → ResultW 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept; RFWEW high on each.
- Load beat with MtoRFSel=1, DMOutM=0xDEADBEEF, ALUOutM=0x4 → ResultW=0xDEADBEEF.
- Jump beat with JumpM=1, PCPlus4M=0x104 → ResultW=0x104.
- rtd=0 with RFWE=1 → RFWEW stays 0 while ValidW=1.
- Hold ReadyW=0, send 0xA, 0xB → OccW=2, ReadyM=0 the next cycle. Release ReadyW → 0xA, then 0xB, in order; ReadyM returns to 1. Without the macro: OccW max 1, and ReadyM tracks ReadyW combinationally.
- With OccW=2, assert FlushM together with ValidM=1 (0xC) and ReadyW=1 → head 0xA commits, then OccW=0, ValidW=0, and 0xC is never output.
- Assert RST_N=0 asynchronously mid-stream → ValidW=0, RFWEW=0, ResultW=0 immediately; ReadyM=1.
